// File: rtl/shift_register_param.sv
// shift_register_param: parametrised load/shift register with five shift modes,
// a single-shift strobe and an auto-shift engine (N shifts from one start pulse)
// with a busy/done handshake.
// Optional feature macro: SHREG_PARITY_EN (combinational XOR-reduction parity of pout).
module shift_register_param #(
    parameter int WIDTH = 10,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] pin,
    input  logic             sload,
    input  logic             serin,
    input  logic [2:0]       mode,
    input  logic             sshift,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             lout,
    output logic [WIDTH-1:0] pout,
    output logic             parity
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    typedef enum logic [2:0] {
        M_SHL = 3'b000,
        M_SHR = 3'b001,
        M_ROL = 3'b010,
        M_ROR = 3'b011,
        M_ASR = 3'b100
    } mode_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   pout_q, pout_d;
    logic               lout_q, lout_d;
    logic               done_q, done_d;

    logic [2:0]         sh_mode;
    logic [WIDTH-1:0]   sh_pout;
    logic               sh_lout;

    // Shifted value for the active mode: latched mode while running, live mode otherwise
    always_comb begin
        sh_mode = (state_q == S_RUN) ? mode_q : mode;
        sh_pout = pout_q;
        sh_lout = lout_q;
        case (sh_mode)
            M_SHL: begin
                sh_pout = {pout_q[WIDTH-2:0], serin};
                sh_lout = pout_q[WIDTH-1];
            end
            M_SHR: begin
                sh_pout = {serin, pout_q[WIDTH-1:1]};
                sh_lout = pout_q[0];
            end
            M_ROL: begin
                sh_pout = {pout_q[WIDTH-2:0], pout_q[WIDTH-1]};
                sh_lout = pout_q[WIDTH-1];
            end
            M_ROR: begin
                sh_pout = {pout_q[0], pout_q[WIDTH-1:1]};
                sh_lout = pout_q[0];
            end
            M_ASR: begin
                sh_pout = {pout_q[WIDTH-1], pout_q[WIDTH-1:1]};
                sh_lout = pout_q[0];
            end
            default: begin
                sh_pout = pout_q;
                sh_lout = lout_q;
            end
        endcase
    end

    // Next-state: clr > sload > auto-shift step > start > sshift > hold
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        pout_d  = pout_q;
        lout_d  = lout_q;
        done_d  = 1'b0;
        if (clr) begin
            state_d = S_IDLE;
            count_d = '0;
            mode_d  = '0;
            pout_d  = '0;
            lout_d  = 1'b0;
        end else if (sload) begin
            // a load during RUN aborts the sequence without a done pulse
            state_d = S_IDLE;
            count_d = '0;
            pout_d  = pin;
            lout_d  = 1'b0;
        end else if (state_q == S_RUN) begin
            pout_d  = sh_pout;
            lout_d  = sh_lout;
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end else if (start) begin
            if (cnt != '0) begin
                state_d = S_RUN;
                count_d = cnt;
                mode_d  = mode;
            end else begin
                done_d  = 1'b1;
            end
        end else if (sshift) begin
            pout_d = sh_pout;
            lout_d = sh_lout;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            mode_q  <= '0;
            pout_q  <= '0;
            lout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            pout_q  <= pout_d;
            lout_q  <= lout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign lout = lout_q;
    assign pout = pout_q;

`ifdef SHREG_PARITY_EN
    assign parity = ^pout_q;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_shift_register_param.sv
// Self-checking bench for shift_register_param (WIDTH=10): expected outputs are
// queued when stimulus is driven and popped/compared one cycle later.
module tb_shift_register_param;

    localparam int W  = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, clr, sload, serin, sshift, start;
    logic [W-1:0]  pin;
    logic [2:0]    mode;
    logic [CW-1:0] cnt;
    logic          busy, done, lout, parity;
    logic [W-1:0]  pout;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] p;
        logic         l;
        logic         b;
        logic         d;
    } exp_t;

    exp_t sb[$];

    logic [W-1:0] e_pout;
    logic         e_lout;

    shift_register_param #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .pin(pin), .sload(sload),
        .serin(serin), .mode(mode), .sshift(sshift), .start(start),
        .cnt(cnt), .busy(busy), .done(done), .lout(lout), .pout(pout),
        .parity(parity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [W:0] ref_shift(input logic [2:0] m, input logic [W-1:0] p,
                                             input logic l, input logic s);
        case (m)
            3'd0:    return {p[W-1], p[W-2:0], s};
            3'd1:    return {p[0], s, p[W-1:1]};
            3'd2:    return {p[W-1], p[W-2:0], p[W-1]};
            3'd3:    return {p[0], p[0], p[W-1:1]};
            3'd4:    return {p[0], p[W-1], p[W-1:1]};
            default: return {l, p};
        endcase
    endfunction

    task automatic push(input string tag, input logic b, input logic d);
        exp_t e;
        e.tag = tag; e.p = e_pout; e.l = e_lout; e.b = b; e.d = d;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        logic exp_par;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
`ifdef SHREG_PARITY_EN
        exp_par = ^e.p;
`else
        exp_par = 1'b0;
`endif
        chk({e.tag, ".pout"},   32'(pout),   32'(e.p));
        chk({e.tag, ".lout"},   32'(lout),   32'(e.l));
        chk({e.tag, ".busy"},   32'(busy),   32'(e.b));
        chk({e.tag, ".done"},   32'(done),   32'(e.d));
        chk({e.tag, ".parity"}, 32'(parity), 32'(exp_par));
    endtask

    task automatic tick_check();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic do_load(input logic [W-1:0] v);
        sload = 1'b1; pin = v;
        e_pout = v; e_lout = 1'b0;
        push("load", 1'b0, 1'b0);
        tick_check();
        sload = 1'b0;
    endtask

    task automatic do_sshift(input logic [2:0] m, input logic s, input logic en);
        sshift = en; mode = m; serin = s;
        if (en) {e_lout, e_pout} = ref_shift(m, e_pout, e_lout, s);
        push(en ? "sshift" : "hold", 1'b0, 1'b0);
        tick_check();
        sshift = 1'b0;
    endtask

    // Full auto-shift with random mode/sshift noise on the ignored inputs
    task automatic do_auto(input logic [2:0] m, input int unsigned n);
        mode = m; cnt = CW'(n); start = 1'b1;
        push("start", n != 0, n == 0);
        tick_check();
        start = 1'b0;
        for (int unsigned i = 1; i <= n; i++) begin
            serin  = 1'($urandom);
            mode   = 3'($urandom_range(0, 7));
            sshift = 1'($urandom);
            start  = 1'($urandom);
            {e_lout, e_pout} = ref_shift(m, e_pout, e_lout, serin);
            push("run", i < n, i == n);
            tick_check();
        end
        sshift = 1'b0; start = 1'b0; mode = m;
        push("done_clr", 1'b0, 1'b0);
        tick_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; sload = 1'b0; serin = 1'b0; sshift = 1'b0;
        start = 1'b0; pin = '0; mode = '0; cnt = '0;
        e_pout = '0; e_lout = 1'b0;
        #12;
        push("reset", 1'b0, 1'b0);
        check_now();
        rst = 1'b0;
        @(posedge clk); #1;

        // Async reset in the middle of an auto-shift
        do_load(10'h3FF);
        mode = 3'd0; cnt = 4'd5; start = 1'b1; serin = 1'b0;
        push("ar_start", 1'b1, 1'b0);
        tick_check();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            {e_lout, e_pout} = ref_shift(3'd0, e_pout, e_lout, 1'b0);
            push("ar_run", 1'b1, 1'b0);
            tick_check();
        end
        #2 rst = 1'b1;
        #1;
        e_pout = '0; e_lout = 1'b0;
        push("async_rst", 1'b0, 1'b0);
        check_now();
        rst = 1'b0;
        push("post_rst", 1'b0, 1'b0);
        tick_check();

        // SHL single shifts
        do_load(10'b1000000001);
        do_sshift(3'd0, 1'b0, 1'b1);
        chk("shl_first_lout", 32'(lout), 32'd1);
        do_sshift(3'd0, 1'b0, 1'b1);
        do_sshift(3'd0, 1'b0, 1'b1);
        chk("shl3_pout", 32'(pout), 32'h008);
        chk("shl3_lout", 32'(lout), 32'd0);

        // ASR auto-shift x3
        do_load(10'h200);
        do_auto(3'd4, 3);
        chk("asr3_pout", 32'(pout), 32'h3C0);

        // ROR by full width, then ROL by width+1
        do_load(10'h001);
        do_auto(3'd3, 10);
        chk("ror10_pout", 32'(pout), 32'h001);
        do_auto(3'd2, 11);
        chk("rol11_pout", 32'(pout), 32'h002);

        // cnt=0 start
        do_auto(3'd0, 0);
        chk("cnt0_pout", 32'(pout), 32'h002);

        // sload aborts a running sequence on the 3rd busy cycle
        mode = 3'd0; cnt = 4'd6; start = 1'b1; serin = 1'b1;
        push("ab_start", 1'b1, 1'b0);
        tick_check();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            {e_lout, e_pout} = ref_shift(3'd0, e_pout, e_lout, 1'b1);
            push("ab_run", 1'b1, 1'b0);
            tick_check();
        end
        sload = 1'b1; pin = 10'h155;
        e_pout = 10'h155; e_lout = 1'b0;
        push("abort", 1'b0, 1'b0);
        tick_check();
        sload = 1'b0;
        push("abort_nodone", 1'b0, 1'b0);
        tick_check();
`ifdef SHREG_PARITY_EN
        chk("parity_155", 32'(parity), 32'd1);
`else
        chk("parity_off", 32'(parity), 32'd0);
`endif

        // clr beats sload while running
        do_load(10'h2AA);
        mode = 3'd1; cnt = 4'd4; start = 1'b1;
        push("clr_start", 1'b1, 1'b0);
        tick_check();
        start = 1'b0; serin = 1'b1;
        {e_lout, e_pout} = ref_shift(3'd1, e_pout, e_lout, 1'b1);
        push("clr_run", 1'b1, 1'b0);
        tick_check();
        clr = 1'b1; sload = 1'b1; pin = 10'h3FF;
        e_pout = '0; e_lout = 1'b0;
        push("clr", 1'b0, 1'b0);
        tick_check();
        clr = 1'b0; sload = 1'b0;

        // Random single shifts and holds over all mode codes
        do_load(10'h2D3);
        for (int k = 0; k < 40; k++)
            do_sshift(3'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 3) != 0));

        // SHR auto-shift past width keeps filling with serin
        do_auto(3'd1, 12);

        if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
